trap_sequencer: RTL and testbench

Sequences machine-mode trap entry and return around the interrupt controller and CSR file. It accepts an interrupt request with its cause, a synchronous exception from the commit stage, or an `mret`, and then drives the rest of the trap. That means flushing the pipeline, writing `mepc`/`mcause`, pulsing the `mstatus` enter/return updates, and redirecting fetch to the handler or the return address. It sits between the interrupt controller, the MEM/WB commit point, the CSR file and the IF-stage PC mux.

---
 rtl/trap_sequencer_pkg.sv | 29 ++
 rtl/trap_vector_calc.sv | 30 +++
 rtl/trap_sequencer.sv | 119 +++++++++++
 tb/tb_trap_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM encoding,
// mtvec mode values and the standard cause codes.
package trap_sequencer_pkg;

  typedef enum logic [1:0] {
    TRAP_ST_IDLE   = 2'd0,
    TRAP_ST_SAVE   = 2'd1,
    TRAP_ST_VECTOR = 2'd2,
    TRAP_ST_RETURN = 2'd3
  } trap_state_e;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  // Interrupt causes carry bit 31; exception causes do not.
  localparam logic [31:0] CAUSE_MSI           = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI           = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI           = 32'h8000_000B;
  localparam logic [31:0] CAUSE_INSTR_MISALGN = 32'h0000_0000;
  localparam logic [31:0] CAUSE_INSTR_FAULT   = 32'h0000_0001;
  localparam logic [31:0] CAUSE_ILLEGAL_INSTR = 32'h0000_0002;
  localparam logic [31:0] CAUSE_BREAKPOINT    = 32'h0000_0003;
  localparam logic [31:0] CAUSE_LOAD_MISALGN  = 32'h0000_0004;
  localparam logic [31:0] CAUSE_LOAD_FAULT    = 32'h0000_0005;
  localparam logic [31:0] CAUSE_STORE_MISALGN = 32'h0000_0006;
  localparam logic [31:0] CAUSE_STORE_FAULT   = 32'h0000_0007;
  localparam logic [31:0] CAUSE_ECALL_M       = 32'h0000_000B;

endpackage

// File: rtl/trap_vector_calc.sv
// Handler PC from mtvec and the latched cause. Vectored mode is only
// honoured when TRAP_VECTORED_EN is defined; otherwise the base is used.
module trap_vector_calc
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] cause,
  input  logic            is_irq,
  output logic [XLEN-1:0] handler_pc
);

  logic [XLEN-1:0] w_base;
  assign w_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  logic w_vectored;
  logic w_unused;
  // Mode 2'b1x falls through to direct; exceptions always land on the base.
  assign w_vectored = (mtvec[1:0] == MTVEC_MODE_VECTORED) && is_irq;
  assign handler_pc = w_vectored ? (w_base + XLEN'({cause[4:0], 2'b00})) : w_base;
  assign w_unused   = ^cause[XLEN-1:5];
`else
  logic w_unused;
  assign handler_pc = w_base;
  assign w_unused   = ^{cause, is_irq, mtvec[1:0]};
`endif

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry/return sequencer between the interrupt controller,
// commit point, CSR file and fetch PC mux. Optional macro: TRAP_VECTORED_EN.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            interrupt_req,
  input  logic [XLEN-1:0] interrupt_cause,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            mret_valid,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            flush,
  output logic            stall,
  output logic            mepc_we,
  output logic [XLEN-1:0] mepc_wdata,
  output logic            mcause_we,
  output logic [XLEN-1:0] mcause_wdata,
  output logic            trap_enter,
  output logic            trap_return,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  trap_state_e     r_state, w_next;
  logic [XLEN-1:0] cause_q, epc_q;
  logic            w_idle, w_take_irq, w_take_exc, w_take_mret, w_accept;
  logic [XLEN-1:0] w_handler_pc;

  assign w_idle      = (r_state == TRAP_ST_IDLE);
  // An interrupt needs a real instruction at commit to supply a valid epc.
  assign w_take_irq  = w_idle & interrupt_req & commit_valid;
  assign w_take_exc  = w_idle & ~w_take_irq & exc_valid;
  assign w_take_mret = w_idle & ~w_take_irq & ~exc_valid & mret_valid;
  // Gated by rst_n so the Mealy flush also drops while reset is held.
  assign w_accept    = rst_n & (w_take_irq | w_take_exc | w_take_mret);

  trap_vector_calc #(.XLEN(XLEN)) u_vec (
    .mtvec      (mtvec),
    .cause      (cause_q),
    .is_irq     (cause_q[XLEN-1]),
    .handler_pc (w_handler_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= TRAP_ST_IDLE;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      r_state <= w_next;
      if (w_take_irq) begin
        cause_q <= interrupt_cause;
        epc_q   <= commit_pc;
      end else if (w_take_exc) begin
        cause_q <= exc_cause;
        epc_q   <= exc_pc;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    flush          = 1'b0;
    busy           = 1'b0;
    mepc_we        = 1'b0;
    mepc_wdata     = '0;
    mcause_we      = 1'b0;
    mcause_wdata   = '0;
    trap_enter     = 1'b0;
    trap_return    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (r_state)
      TRAP_ST_IDLE: begin
        flush = w_accept;
        if (w_take_irq || w_take_exc) w_next = TRAP_ST_SAVE;
        else if (w_take_mret)         w_next = TRAP_ST_RETURN;
      end
      TRAP_ST_SAVE: begin
        flush        = 1'b1;
        busy         = 1'b1;
        mepc_we      = 1'b1;
        mepc_wdata   = {epc_q[XLEN-1:2], 2'b00};
        mcause_we    = 1'b1;
        mcause_wdata = cause_q;
        trap_enter   = 1'b1;
        w_next       = TRAP_ST_VECTOR;
      end
      TRAP_ST_VECTOR: begin
        flush          = 1'b1;
        busy           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = w_handler_pc;
        w_next         = TRAP_ST_IDLE;
      end
      TRAP_ST_RETURN: begin
        flush          = 1'b1;
        busy           = 1'b1;
        trap_return    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = {mepc[XLEN-1:2], 2'b00};
        w_next         = TRAP_ST_IDLE;
      end
      default: w_next = TRAP_ST_IDLE;
    endcase
  end

  assign stall = busy;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench: a timeline model of expected output cycles, directed
// scenarios with literal expectations, then randomized traffic.
module tb_trap_sequencer;

  logic        clk, rst_n;
  logic        interrupt_req, exc_valid, mret_valid, commit_valid;
  logic [31:0] interrupt_cause, exc_cause, exc_pc, commit_pc, mtvec, mepc;
  logic        flush, stall, mepc_we, mcause_we, trap_enter, trap_return;
  logic        redirect_valid, busy;
  logic [31:0] mepc_wdata, mcause_wdata, redirect_pc;

  int passed = 0;
  int total  = 0;

  trap_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .interrupt_req(interrupt_req), .interrupt_cause(interrupt_cause),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .mret_valid(mret_valid), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .mtvec(mtvec), .mepc(mepc),
    .flush(flush), .stall(stall),
    .mepc_we(mepc_we), .mepc_wdata(mepc_wdata),
    .mcause_we(mcause_we), .mcause_wdata(mcause_wdata),
    .trap_enter(trap_enter), .trap_return(trap_return),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each queued entry is what one future cycle must look like.
  typedef struct {
    int          kind;   // 1 = save CSRs, 2 = jump to handler, 3 = return
    logic [31:0] epc;
    logic [31:0] cause;
  } ent_t;
  ent_t sched[$];

  function automatic logic [103:0] outs();
    return {flush, stall, busy, mepc_we, mcause_we, trap_enter, trap_return,
            redirect_valid, mepc_wdata, mcause_wdata, redirect_pc};
  endfunction

  function automatic logic [31:0] handler(logic [31:0] tv, logic [31:0] c);
    logic [31:0] base;
    base = tv & 32'hFFFF_FFFC;
`ifdef TRAP_VECTORED_EN
    if (c[31] && tv[1:0] == 2'b01) return base + (c % 32) * 4;
`endif
    return base;
  endfunction

  task automatic chk(input string nm, input logic [103:0] act, input logic [103:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Compare the DUT against the timeline, then advance it by one cycle.
  task automatic model_check();
    logic        f, b, mw, cw, te, tr, rv;
    logic [31:0] mwd, cwd, rpc;
    ent_t        e;
    {f, b, mw, cw, te, tr, rv} = '0;
    {mwd, cwd, rpc} = '0;
    if (sched.size() > 0) begin
      e = sched[0];
      f = 1'b1; b = 1'b1;
      if (e.kind == 1) begin
        mw = 1'b1; cw = 1'b1; te = 1'b1;
        mwd = e.epc & 32'hFFFF_FFFC; cwd = e.cause;
      end else if (e.kind == 2) begin
        rv = 1'b1; rpc = handler(mtvec, e.cause);
      end else begin
        tr = 1'b1; rv = 1'b1; rpc = mepc & 32'hFFFF_FFFC;
      end
    end else begin
      f = (interrupt_req && commit_valid) || exc_valid || mret_valid;
    end
    chk("cycle", outs(), {f, b, b, mw, cw, te, tr, rv, mwd, cwd, rpc});
    if (sched.size() > 0) void'(sched.pop_front());
    else if (interrupt_req && commit_valid) begin
      sched.push_back('{1, commit_pc, interrupt_cause});
      sched.push_back('{2, commit_pc, interrupt_cause});
    end else if (exc_valid) begin
      sched.push_back('{1, exc_pc, exc_cause});
      sched.push_back('{2, exc_pc, exc_cause});
    end else if (mret_valid) sched.push_back('{3, 32'h0, 32'h0});
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    interrupt_req = 0; exc_valid = 0; mret_valid = 0; commit_valid = 0;
  endtask

  task automatic trap_redirect(input string nm, input logic [31:0] tv,
                               input logic is_irq, input logic [31:0] c,
                               input logic [31:0] exp_pc);
    mtvec = tv; commit_valid = 1; commit_pc = 32'h300; exc_pc = 32'h300;
    if (is_irq) begin interrupt_req = 1; interrupt_cause = c; end
    else begin exc_valid = 1; exc_cause = c; end
    at_neg(); next(); quiet();
    at_neg(); next();
    at_neg();
    chk(nm, {72'h0, redirect_pc}, {72'h0, exp_pc});
    next();
  endtask

  initial begin
    rst_n = 0; quiet();
    interrupt_cause = 0; exc_cause = 0; exc_pc = 0; commit_pc = 0;
    mtvec = 0; mepc = 0;
    #3;
    chk("reset_outputs", outs(), '0);
    next(); next();
    rst_n = 1;

    // Timer interrupt
    interrupt_req = 1; interrupt_cause = 32'h8000_0007;
    commit_valid = 1; commit_pc = 32'h100; mtvec = 32'h200;
    at_neg();
    chk("timer_flush_T", {103'h0, flush}, 104'h1);
    next(); quiet();
    at_neg();
    chk("timer_mepc", {72'h0, mepc_wdata}, {72'h0, 32'h100});
    chk("timer_mcause", {72'h0, mcause_wdata}, {72'h0, 32'h8000_0007});
    chk("timer_enter", {103'h0, trap_enter}, 104'h1);
    next();
    at_neg();
    chk("timer_redirect", {71'h0, redirect_valid, redirect_pc}, {71'h0, 1'b1, 32'h200});
    next();
    at_neg();
    chk("timer_idle", {103'h0, busy}, 104'h0);
    next();

    // Exception and interrupt together: interrupt wins
    exc_valid = 1; exc_cause = 2; exc_pc = 32'h40;
    interrupt_req = 1; interrupt_cause = 32'h8000_000B;
    commit_valid = 1; commit_pc = 32'h40;
    at_neg(); next(); quiet();
    at_neg();
    chk("both_mcause", {72'h0, mcause_wdata}, {72'h0, 32'h8000_000B});
    chk("both_mepc", {72'h0, mepc_wdata}, {72'h0, 32'h40});
    next(); at_neg(); next();

    // mret
    mret_valid = 1; mepc = 32'h104;
    at_neg(); next(); quiet();
    at_neg();
    chk("mret_return", {70'h0, trap_return, redirect_valid, redirect_pc},
        {70'h0, 2'b11, 32'h104});
    next();
    at_neg();
    chk("mret_busy_low", {103'h0, busy}, 104'h0);
    next();

    // Vector mode handling
`ifdef TRAP_VECTORED_EN
    trap_redirect("vec_irq", 32'h201, 1'b1, 32'h8000_0007, 32'h21C);
`else
    trap_redirect("vec_irq", 32'h201, 1'b1, 32'h8000_0007, 32'h200);
`endif
    trap_redirect("vec_exc", 32'h201, 1'b0, 32'h2, 32'h200);
    trap_redirect("mode_1x", 32'h203, 1'b1, 32'h8000_0003, 32'h200);

    // Bubble: interrupt with no committing instruction
    interrupt_req = 1; commit_valid = 0;
    at_neg();
    chk("bubble_flush", {103'h0, flush}, 104'h0);
    next(); quiet();
    at_neg();
    chk("bubble_busy", {103'h0, busy}, 104'h0);
    next();

    // Reset while in SAVE
    interrupt_req = 1; interrupt_cause = 32'h8000_0007; commit_valid = 1; commit_pc = 32'h500;
    at_neg(); next(); quiet();
    #1 rst_n = 0;
    #1 chk("reset_in_save", outs(), '0);
    sched.delete();
    next();
    rst_n = 1;
    at_neg(); next();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      interrupt_req   = ($urandom_range(3) == 0);
      commit_valid    = ($urandom_range(3) != 0);
      exc_valid       = ($urandom_range(3) == 0);
      mret_valid      = ($urandom_range(5) == 0);
      interrupt_cause = 32'h8000_0000 | ($urandom % 32);
      exc_cause       = $urandom % 16;
      exc_pc          = $urandom;
      commit_pc       = $urandom;
      mtvec           = $urandom;
      mepc            = $urandom;
      at_neg();
      next();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
